// File: rtl/daq_run_ctrl.sv
// Run-level sequencer: issues start pulses to the per-acquisition DAQ FSM, counts
// completed cycles, inserts inter-cycle gaps and recovers hung cycles via a watchdog.
module daq_run_ctrl #(
    parameter int T_WATCHDOG = 40000000,
    parameter int WD_W       = 26,
    parameter int RST_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        run_start,
    input  logic        run_stop,
    input  logic [15:0] acq_number,
    input  logic [15:0] gap_cycles,
    input  logic        once_end,
    output logic        daq_start,
    output logic        daq_reset_n,
    output logic        run_busy,
    output logic        run_done,
    output logic [15:0] acq_done_cnt,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_END = 3'd2,
        ABORT    = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [15:0]       target;
    logic [15:0]       gap_reg;
    logic [15:0]       gap_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic              stop_pending;

    logic              stop_now;
    logic              wd_expired;
    logic              rst_last;
    logic              gap_last;
    logic [15:0]       cnt_inc;

    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stop_now   = stop_pending | run_stop;
        wd_expired = (wd_cnt == WD_W'(T_WATCHDOG - 1));
        rst_last   = (rst_cnt == RST_W'(RST_CYCLES - 1));
        // A zero gap still yields one GAP cycle: 1 >= 0 is always true.
        gap_last   = (({1'b0, gap_cnt} + 17'd1) >= {1'b0, gap_reg});
        cnt_inc    = (acq_done_cnt == 16'hFFFF) ? 16'hFFFF : acq_done_cnt + 16'd1;
        case (state)
            IDLE: begin
                if (run_start && !run_stop) next_state = ARM;
            end
            ARM: begin
                next_state = run_stop ? DONE : WAIT_END;
            end
            WAIT_END: begin
                // once_end takes priority over a simultaneous watchdog expiry
                if (once_end) begin
                    if (stop_now || (target != 16'd0 && cnt_inc == target)) next_state = DONE;
                    else next_state = GAP;
                end else if (wd_expired) begin
                    next_state = ABORT;
                end
            end
            ABORT: begin
                if (rst_last) next_state = stop_now ? DONE : GAP;
            end
            GAP: begin
                if (run_stop) next_state = DONE;
                else if (gap_last) next_state = ARM;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            daq_start    <= 1'b0;
            daq_reset_n  <= 1'b1;
            run_busy     <= 1'b0;
            run_done     <= 1'b0;
            acq_done_cnt <= 16'd0;
            timeout_err  <= 1'b0;
            target       <= 16'd0;
            gap_reg      <= 16'd0;
            gap_cnt      <= 16'd0;
            wd_cnt       <= '0;
            rst_cnt      <= '0;
            stop_pending <= 1'b0;
        end else begin
            daq_start   <= (state == ARM) && (next_state == WAIT_END);
            run_done    <= (state == DONE);
            run_busy    <= (state != IDLE);
            daq_reset_n <= (next_state != ABORT);
            case (state)
                IDLE: begin
                    if (run_start && !run_stop) begin
                        target       <= acq_number;
                        gap_reg      <= gap_cycles;
                        acq_done_cnt <= 16'd0;
                        timeout_err  <= 1'b0;
                        stop_pending <= 1'b0;
                    end
                end
                ARM: begin
                    wd_cnt <= '0;
                end
                WAIT_END: begin
                    wd_cnt  <= wd_cnt + WD_W'(1);
                    rst_cnt <= '0;
                    gap_cnt <= 16'd0;
                    if (once_end) acq_done_cnt <= cnt_inc;
                    if (run_stop) stop_pending <= 1'b1;
                    if (next_state == ABORT) timeout_err <= 1'b1;
                end
                ABORT: begin
                    rst_cnt <= rst_cnt + RST_W'(1);
                    gap_cnt <= 16'd0;
                    if (run_stop) stop_pending <= 1'b1;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_daq_run_ctrl.sv
// Directed bench for daq_run_ctrl with a short watchdog (100 cycles) so expiry is reachable.
module tb_daq_run_ctrl;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        run_start;
    logic        run_stop;
    logic [15:0] acq_number;
    logic [15:0] gap_cycles;
    logic        once_end;
    logic        daq_start;
    logic        daq_reset_n;
    logic        run_busy;
    logic        run_done;
    logic [15:0] acq_done_cnt;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    daq_run_ctrl #(
        .T_WATCHDOG (100),
        .WD_W       (8),
        .RST_CYCLES (4)
    ) dut (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .run_start    (run_start),
        .run_stop     (run_stop),
        .acq_number   (acq_number),
        .gap_cycles   (gap_cycles),
        .once_end     (once_end),
        .daq_start    (daq_start),
        .daq_reset_n  (daq_reset_n),
        .run_busy     (run_busy),
        .run_done     (run_done),
        .acq_done_cnt (acq_done_cnt),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    always #5 Clk = ~Clk;

    // cyc == e between edge e and edge e+1
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish before 500000 ns");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_until_cycle(input int n);
        while (cyc < n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [15:0] acq, input logic [15:0] gap);
        acq_number = acq;
        gap_cycles = gap;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
    endtask

    task automatic pulse_stop();
        run_stop = 1'b1;
        tick();
        run_stop = 1'b0;
    endtask

    // once_end is high between edges at and at+1, sampled at edge at+1
    task automatic return_once_end(input int at);
        wait_until_cycle(at);
        once_end = 1'b1;
        tick();
        once_end = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (daq_start) begin
                at = cyc;
                break;
            end
        end
        check(tag, daq_start, 1);
    endtask

    task automatic wait_run_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (run_done) break;
        end
        check(tag, run_done, 1);
    endtask

    task automatic wait_rst_low(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (!daq_reset_n) begin
                at = cyc;
                break;
            end
        end
        check("daq_reset_n_low_seen", daq_reset_n, 0);
    endtask

    task automatic count_starts(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (daq_start || run_done) c++;
        end
    endtask

    initial begin
        int k;
        int s;
        int s1;
        int s2;
        int prev;
        int at;
        int w;
        int c;

        reset_n    = 1'b0;
        run_start  = 1'b0;
        run_stop   = 1'b0;
        acq_number = 16'd0;
        gap_cycles = 16'd0;
        once_end   = 1'b0;
        repeat (3) tick();
        @(negedge Clk);
        check("rst_daq_start", daq_start, 0);
        check("rst_daq_reset_n", daq_reset_n, 1);
        check("rst_run_busy", run_busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_acq_done_cnt", acq_done_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        tick();

        // Fixed run of 3, gap 10, once_end 50 cycles after each start
        pulse_start(16'd3, 16'd10);
        k = cyc;
        acq_number = 16'd7;
        gap_cycles = 16'd99;
        @(negedge Clk);
        check("busy_at_edge_k", run_busy, 0);
        check("start_at_edge_k", daq_start, 0);
        wait_start("start1_seen", 10, s1);
        check("start_latency", s1, k + 1);
        check("busy_at_edge_k1", run_busy, 1);
        @(negedge Clk);
        check("start_width", daq_start, 0);
        return_once_end(s1 + 50);
        wait_start("start2_seen", 100, s2);
        check("spacing_1_2", s2 - s1, 62);
        return_once_end(s2 + 50);
        wait_start("start3_seen", 100, s);
        check("spacing_2_3", s - s2, 62);
        return_once_end(s + 50);
        @(negedge Clk);
        check("fixed_cnt", acq_done_cnt, 3);
        check("fixed_done_early", run_done, 0);
        @(negedge Clk);
        check("fixed_done", run_done, 1);
        check("fixed_busy_with_done", run_busy, 1);
        @(negedge Clk);
        check("fixed_done_width", run_done, 0);
        check("fixed_busy_fall", run_busy, 0);
        count_starts(80, c);
        check("fixed_no_4th_start", c, 0);

        // Continuous run, gap 0, stop during the 5th WAIT_END
        pulse_start(16'd0, 16'd0);
        prev = 0;
        for (int i = 1; i <= 5; i++) begin
            wait_start("cont_start_seen", 20, s);
            if (i > 1) check("cont_spacing", s - prev, 8);
            prev = s;
            if (i < 5) return_once_end(s + 5);
        end
        wait_until_cycle(s + 2);
        pulse_stop();
        return_once_end(s + 6);
        @(negedge Clk);
        check("cont_cnt", acq_done_cnt, 5);
        wait_run_done("cont_done", 5);
        check("cont_idle", state_dbg, 0);
        count_starts(30, c);
        check("cont_no_6th_start", c, 0);

        // Watchdog expiry: once_end withheld on the first cycle
        pulse_start(16'd1, 16'd5);
        wait_start("wd_start1_seen", 10, s1);
        wait_rst_low(150, at);
        check("wd_expiry_time", at, s1 + 100);
        check("wd_timeout_err", timeout_err, 1);
        check("wd_cnt_unchanged", acq_done_cnt, 0);
        w = 0;
        while (daq_reset_n == 1'b0 && w < 20) begin
            w++;
            @(negedge Clk);
        end
        check("wd_reset_width", w, 4);
        wait_start("wd_start2_seen", 30, s2);
        check("wd_restart_time", s2, at + 10);
        return_once_end(s2 + 3);
        @(negedge Clk);
        check("wd_cnt_after", acq_done_cnt, 1);
        check("wd_err_sticky", timeout_err, 1);
        wait_run_done("wd_done", 5);

        // once_end on the watchdog-expiry cycle wins
        pulse_start(16'd1, 16'd0);
        @(negedge Clk);
        check("err_cleared_by_start", timeout_err, 0);
        wait_start("race_start_seen", 10, s);
        return_once_end(s + 99);
        @(negedge Clk);
        check("race_counted", acq_done_cnt, 1);
        check("race_no_abort", daq_reset_n, 1);
        check("race_no_err", timeout_err, 0);
        wait_run_done("race_done", 5);

        // run_start and run_stop together in IDLE
        acq_number = 16'd2;
        run_start  = 1'b1;
        run_stop   = 1'b1;
        tick();
        run_start  = 1'b0;
        run_stop   = 1'b0;
        count_starts(10, c);
        check("both_no_start", c, 0);
        check("both_idle_busy", run_busy, 0);

        // run_stop during GAP ends the run without another start
        pulse_start(16'd0, 16'd30);
        wait_start("gapstop_start_seen", 10, s);
        return_once_end(s + 4);
        wait_until_cycle(s + 10);
        pulse_stop();
        wait_run_done("gapstop_done", 5);
        check("gapstop_cnt", acq_done_cnt, 1);
        count_starts(50, c);
        check("gapstop_no_start", c, 0);

        // reset_n low during GAP
        pulse_start(16'd2, 16'd20);
        wait_start("rstgap_start_seen", 10, s);
        return_once_end(s + 3);
        wait_until_cycle(s + 8);
        @(negedge Clk);
        check("rstgap_cnt_before", acq_done_cnt, 1);
        check("rstgap_in_gap", state_dbg, 4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge Clk);
        check("rstgap_busy", run_busy, 0);
        check("rstgap_cnt", acq_done_cnt, 0);
        check("rstgap_daq_start", daq_start, 0);
        check("rstgap_run_done", run_done, 0);
        check("rstgap_daq_reset_n", daq_reset_n, 1);
        check("rstgap_state", state_dbg, 0);
        count_starts(40, c);
        check("rstgap_quiet", c, 0);
        pulse_start(16'd1, 16'd0);
        wait_start("fresh_start_seen", 10, s);
        return_once_end(s + 10);
        wait_run_done("fresh_done", 5);
        check("fresh_cnt", acq_done_cnt, 1);
        check("fresh_err", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/daq_run_ctrl.md
Name: daq_run_ctrl

Overview:
- Run-level sequencer placed directly upstream of the per-acquisition ASIC DAQ FSM.
- Turns USB run commands into one-cycle start pulses to that FSM and counts the completed acquisition+readout cycles it reports on Once_end.
- Inserts a programmable gap between cycles and supports fixed-count or continuous runs.
- A watchdog recovers a hung cycle: it resets the downstream FSM and flags the error.

Parameters:
- T_WATCHDOG, 40000000, Clk cycles allowed from daq_start to once_end (1 s at 40 MHz); must be ≥2.
- WD_W, 26, watchdog counter width; must satisfy 2^WD_W > T_WATCHDOG.
- RST_CYCLES, 4, Clk cycles daq_reset_n is held low after a watchdog expiry; must be ≥1.

Ports:
- Clk  input  1  40 MHz system clock.
- reset_n  input  1  One clock; reset is synchronous and active-low.
- run_start  input  1  One-cycle pulse: begin a run.
- run_stop  input  1  One-cycle pulse: end the run gracefully.
- acq_number  input  16  Number of cycles per run; 0 means continuous.
- gap_cycles  input  16  Idle Clk cycles between cycles.
- once_end  input  1  One-cycle pulse from the downstream FSM: cycle finished.
- daq_start  output  1  One-cycle start pulse to the downstream FSM.
- daq_reset_n  output  1  Active-low reset to the downstream FSM, driven low only on watchdog expiry.
- run_busy  output  1  High whenever state ≠ IDLE.
- run_done  output  1  One-cycle pulse when a run ends.
- acq_done_cnt  output  16  Cycles completed in the current run; saturates at 16'hFFFF.
- timeout_err  output  1  Sticky; set on watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset (reset_n low at a Clk edge) values:
  - daq_start = 0, run_done = 0, run_busy = 0.
  - daq_reset_n = 1, acq_done_cnt = 0, timeout_err = 0.
  - state = IDLE; all internal counters and stop_pending = 0.
- Reset mid-run aborts immediately to these values; no run_done is issued.
- States: IDLE, ARM, WAIT_END, ABORT, GAP, DONE.
- IDLE:
  - run_start=1 and run_stop=0: latch acq_number→target and gap_cycles→gap_reg; clear acq_done_cnt, timeout_err and stop_pending; go to ARM.
  - run_start and run_stop in the same cycle: stay in IDLE.
  - Input changes after the latch have no effect until the next run.
- ARM: lasts one cycle. Sets daq_start=1 (visible for exactly the next cycle), clears the watchdog, then goes to WAIT_END.
- Latency: run_start sampled at edge k → daq_start high between edges k+1 and k+2.
- WAIT_END:
  - The watchdog increments every cycle.
  - On once_end=1:
    - acq_done_cnt +1, saturating.
    - If stop_pending, or target≠0 and the new count == target → DONE.
    - Otherwise → GAP.
  - Watchdog reaching T_WATCHDOG−1 with once_end=0 → ABORT.
  - If once_end and expiry happen in the same cycle, once_end wins.
- ABORT:
  - daq_reset_n=0 for RST_CYCLES cycles and timeout_err=1.
  - acq_done_cnt is not incremented.
  - Then → DONE if stop_pending, else → GAP.
- GAP:
  - Counts gap_reg cycles, then → ARM.
  - gap_reg=0 gives a single GAP cycle, so consecutive daq_start pulses are ≥3 cycles apart beyond the once_end latency.
- DONE: run_done=1 for one cycle, then → IDLE.
- run_stop handling:
  - In WAIT_END or ABORT: sets stop_pending; the current cycle finishes first.
  - In ARM or GAP: → DONE next cycle; no further daq_start is issued.
  - In IDLE or DONE: ignored.
- run_start while not in IDLE: ignored.
- once_end outside WAIT_END: ignored and not counted.
- Continuous mode (target=0): loops until run_stop; acq_done_cnt holds at FFFF without wrapping.

Test Plan:
- acq_number=3, gap_cycles=10, once_end returned 50 cycles after each daq_start → exactly 3 daq_start pulses, consecutive pulses 62 cycles apart, acq_done_cnt=3, run_done one cycle after the 3rd once_end, run_busy falls with it.
- Latency: run_start at edge k → daq_start high only in cycle k+1..k+2; run_busy high from edge k+1.
- acq_number=0, gap=0, run_stop issued mid-WAIT_END of the 5th cycle → the 5th once_end is counted, then DONE; acq_done_cnt=5, no 6th daq_start.
- T_WATCHDOG=100 in the bench, once_end withheld → daq_reset_n low for exactly 4 cycles starting 100 cycles after ARM, timeout_err=1, next daq_start issued after the gap, acq_done_cnt unchanged.
- Simultaneous events: run_start+run_stop in IDLE → stays IDLE; once_end on the watchdog-expiry cycle → counted, no ABORT.
- reset_n low during GAP → all outputs at reset values next cycle; a fresh run_start then clears timeout_err and restarts normally.
